// File: rtl/wdg_cfg_arb.sv
// Watchdog config arbiter: CPU pass-through plus an autonomous prescaler/timeout/control write sequence.
// Latency: wdg_req one cycle after cpu_req or pending trigger; cpu_ack combinational with wdg_ack.
// Backpressure: CPU stalled while sequencing; an unacked request is dropped after ACK_TIMEOUT cycles. Optional macro WDG_CFG_LOCK_EN.
module wdg_cfg_arb #(
    parameter logic [3:0]  PRE_ADDR    = 4'h0,
    parameter logic [31:0] PRE_VAL     = 32'd99,
    parameter logic [3:0]  TO_ADDR     = 4'h1,
    parameter logic [31:0] TO_VAL      = 32'd1000,
    parameter logic [3:0]  CTRL_ADDR   = 4'h2,
    parameter logic [31:0] CTRL_VAL    = 32'h1,
    parameter int          ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        sys_res,
    input  logic        wdg_res_n,
    input  logic        seq_start,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ack,
    output logic        cpu_err,
    output logic [31:0] cpu_rdata,
    output logic        wdg_req,
    output logic        wdg_we,
    output logic [3:0]  wdg_addr,
    output logic [31:0] wdg_wdata,
    input  logic        wdg_ack,
    input  logic [31:0] wdg_rdata,
    output logic        seq_busy,
    output logic        seq_done,
    output logic        seq_err
);

`ifdef WDG_CFG_LOCK_EN
    typedef enum logic [1:0] {S_IDLE, S_CPU, S_SEQ, S_LOCKERR} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_CPU, S_SEQ} state_t;
`endif

    localparam logic [7:0] TMO_MAX = 8'(ACK_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        pend_q;
    logic        res_q;
    logic [1:0]  idx_q;
    logic [7:0]  cnt_q;
    logic        lat_we_q;
    logic [3:0]  lat_addr_q;
    logic [31:0] lat_wdata_q;
    logic        done_q, err_q;

    logic trig, tmo_hit, go_seq, go_cpu, seq_fin, seq_tmo;

    assign trig    = seq_start | (wdg_res_n & ~res_q);
    assign tmo_hit = (cnt_q == TMO_MAX) && !wdg_ack;

    always_comb begin
        state_d   = state_q;
        go_seq    = 1'b0;
        go_cpu    = 1'b0;
        seq_fin   = 1'b0;
        seq_tmo   = 1'b0;
        wdg_req   = 1'b0;
        wdg_we    = 1'b0;
        wdg_addr  = 4'h0;
        wdg_wdata = 32'h0;
        cpu_ack   = 1'b0;
        cpu_err   = 1'b0;
        cpu_rdata = 32'h0;
        case (state_q)
            S_IDLE: begin
                if (pend_q && wdg_res_n) begin
                    state_d = S_SEQ;
                    go_seq  = 1'b1;
                end else if (cpu_req) begin
`ifdef WDG_CFG_LOCK_EN
                    if (cpu_we && (cpu_addr == CTRL_ADDR) && done_q) begin
                        state_d = S_LOCKERR;
                    end else begin
                        state_d = S_CPU;
                        go_cpu  = 1'b1;
                    end
`else
                    state_d = S_CPU;
                    go_cpu  = 1'b1;
`endif
                end
            end
            S_CPU: begin
                wdg_req   = 1'b1;
                wdg_we    = lat_we_q;
                wdg_addr  = lat_addr_q;
                wdg_wdata = lat_wdata_q;
                cpu_ack   = wdg_ack | tmo_hit;
                cpu_err   = tmo_hit;
                cpu_rdata = wdg_ack ? wdg_rdata : 32'h0;
                if (wdg_ack || tmo_hit)
                    state_d = S_IDLE;
            end
            S_SEQ: begin
                // Watchdog held in reset: abandon silently, the release edge restarts it.
                if (!wdg_res_n) begin
                    state_d = S_IDLE;
                end else begin
                    wdg_req = 1'b1;
                    wdg_we  = 1'b1;
                    case (idx_q)
                        2'd0:    begin wdg_addr = PRE_ADDR;  wdg_wdata = PRE_VAL;  end
                        2'd1:    begin wdg_addr = TO_ADDR;   wdg_wdata = TO_VAL;   end
                        default: begin wdg_addr = CTRL_ADDR; wdg_wdata = CTRL_VAL; end
                    endcase
                    if (wdg_ack) begin
                        if (idx_q == 2'd2) begin
                            state_d = S_IDLE;
                            seq_fin = 1'b1;
                        end
                    end else if (tmo_hit) begin
                        state_d = S_IDLE;
                        seq_tmo = 1'b1;
                    end
                end
            end
`ifdef WDG_CFG_LOCK_EN
            S_LOCKERR: begin
                cpu_ack = 1'b1;
                cpu_err = 1'b1;
                state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
        if (sys_res) begin
            wdg_req   = 1'b0;
            wdg_we    = 1'b0;
            wdg_addr  = 4'h0;
            wdg_wdata = 32'h0;
            cpu_ack   = 1'b0;
            cpu_err   = 1'b0;
            cpu_rdata = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (sys_res) begin
            state_q     <= S_IDLE;
            pend_q      <= 1'b0;
            res_q       <= 1'b1;
            idx_q       <= 2'd0;
            cnt_q       <= 8'd0;
            lat_we_q    <= 1'b0;
            lat_addr_q  <= 4'h0;
            lat_wdata_q <= 32'h0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= wdg_res_n;

            if (!wdg_req || wdg_ack || tmo_hit)
                cnt_q <= 8'd0;
            else
                cnt_q <= cnt_q + 8'd1;

            if (go_seq)
                pend_q <= 1'b0;
            else if (state_q != S_SEQ && trig)
                pend_q <= 1'b1;

            if (go_cpu) begin
                lat_we_q    <= cpu_we;
                lat_addr_q  <= cpu_addr;
                lat_wdata_q <= cpu_wdata;
            end

            if (go_seq)
                idx_q <= 2'd0;
            else if (state_q == S_SEQ && wdg_req && wdg_ack)
                idx_q <= idx_q + 2'd1;

            if (go_seq) begin
                done_q <= 1'b0;
                err_q  <= 1'b0;
            end else begin
                if (seq_fin) done_q <= 1'b1;
                if (seq_tmo) err_q  <= 1'b1;
            end
        end
    end

    assign seq_busy = (state_q == S_SEQ) && !sys_res;
    assign seq_done = done_q;
    assign seq_err  = err_q;

endmodule

// File: tb/tb_wdg_cfg_arb.sv
// Directed bench for wdg_cfg_arb: sequencer, CPU pass-through, trigger priority, timeouts, abort, lock.
module tb_wdg_cfg_arb;
    logic        clk = 1'b0;
    logic        sys_res, wdg_res_n, seq_start;
    logic        cpu_req, cpu_we;
    logic [3:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ack, cpu_err;
    logic [31:0] cpu_rdata;
    logic        wdg_req, wdg_we;
    logic [3:0]  wdg_addr;
    logic [31:0] wdg_wdata;
    logic        wdg_ack;
    logic [31:0] wdg_rdata;
    logic        seq_busy, seq_done, seq_err;

    int tests = 0;
    int fails = 0;

    wdg_cfg_arb dut (
        .clk(clk), .sys_res(sys_res), .wdg_res_n(wdg_res_n), .seq_start(seq_start),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
        .wdg_req(wdg_req), .wdg_we(wdg_we), .wdg_addr(wdg_addr), .wdg_wdata(wdg_wdata),
        .wdg_ack(wdg_ack), .wdg_rdata(wdg_rdata),
        .seq_busy(seq_busy), .seq_done(seq_done), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle with all pulse inputs cleared.
    task automatic idle();
        @(negedge clk);
        seq_start = 1'b0;
        cpu_req   = 1'b0;
        wdg_ack   = 1'b0;
        #1;
    endtask

    // One sequencer transfer, acked on its third cycle.
    task automatic seq_xfer(input logic [3:0] a, input logic [31:0] d);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seq_start = 1'b0;
            wdg_ack   = (i == 2);
            #1;
            chk("seq_req",   32'(wdg_req),  32'd1);
            chk("seq_busy",  32'(seq_busy), 32'd1);
            chk("seq_we",    32'(wdg_we),   32'd1);
            chk("seq_addr",  32'(wdg_addr), 32'(a));
            chk("seq_wdata", wdg_wdata,     d);
        end
    endtask

    initial begin
        sys_res = 1'b1; wdg_res_n = 1'b1; seq_start = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 4'h0; cpu_wdata = 32'h0;
        wdg_ack = 1'b0; wdg_rdata = 32'h0;

        // reset
        @(negedge clk); @(negedge clk); #1;
        chk("rst_req",  32'(wdg_req),  32'd0);
        chk("rst_ack",  32'(cpu_ack),  32'd0);
        chk("rst_busy", 32'(seq_busy), 32'd0);
        chk("rst_done", 32'(seq_done), 32'd0);
        chk("rst_err",  32'(seq_err),  32'd0);
        @(negedge clk); sys_res = 1'b0; #1;
        chk("post_rst_req", 32'(wdg_req), 32'd0);

        // full sequence from seq_start
        @(negedge clk); seq_start = 1'b1; #1;
        chk("s1_busy0", 32'(seq_busy), 32'd0);
        idle();
        chk("s1_busy1", 32'(seq_busy), 32'd0);
        seq_xfer(4'h0, 32'd99);
        seq_xfer(4'h1, 32'd1000);
        seq_xfer(4'h2, 32'd1);
        idle();
        chk("s1_busy_end", 32'(seq_busy), 32'd0);
        chk("s1_req_end",  32'(wdg_req),  32'd0);
        chk("s1_done",     32'(seq_done), 32'd1);
        chk("s1_err",      32'(seq_err),  32'd0);

        // CPU read of addr 1, acked on cycle 3
        @(negedge clk); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h1; #1;
        chk("rd_req_c0", 32'(wdg_req), 32'd0);
        @(negedge clk); cpu_req = 1'b0; #1;
        chk("rd_req_c1",  32'(wdg_req),  32'd1);
        chk("rd_we_c1",   32'(wdg_we),   32'd0);
        chk("rd_addr_c1", 32'(wdg_addr), 32'd1);
        chk("rd_ack_c1",  32'(cpu_ack),  32'd0);
        @(negedge clk); wdg_rdata = 32'hABCD; #1;
        chk("rd_rdata_noack", cpu_rdata, 32'h0);
        @(negedge clk); wdg_ack = 1'b1; #1;
        chk("rd_ack_c3",   32'(cpu_ack), 32'd1);
        chk("rd_err_c3",   32'(cpu_err), 32'd0);
        chk("rd_rdata_c3", cpu_rdata,    32'hABCD);
        idle();
        chk("rd_ack_c4",   32'(cpu_ack), 32'd0);
        chk("rd_rdata_c4", cpu_rdata,    32'h0);
        chk("rd_req_c4",   32'(wdg_req), 32'd0);
        wdg_rdata = 32'h0;

        // wdg_res_n rises during a CPU write: CPU finishes, then sequence
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'h5; cpu_wdata = 32'h55; wdg_res_n = 1'b0;
        #1;
        @(negedge clk); cpu_req = 1'b0; wdg_res_n = 1'b1; #1;
        chk("wr_req",   32'(wdg_req),   32'd1);
        chk("wr_we",    32'(wdg_we),    32'd1);
        chk("wr_addr",  32'(wdg_addr),  32'd5);
        chk("wr_wdata", wdg_wdata,      32'h55);
        chk("wr_busy",  32'(seq_busy),  32'd0);
        @(negedge clk); wdg_ack = 1'b1; #1;
        chk("wr_ack",  32'(cpu_ack),  32'd1);
        chk("wr_busy2", 32'(seq_busy), 32'd0);
        idle();
        chk("pri_idle_req",  32'(wdg_req),  32'd0);
        chk("pri_idle_busy", 32'(seq_busy), 32'd0);
        seq_xfer(4'h0, 32'd99);
        chk("pri_done_cleared", 32'(seq_done), 32'd0);
        seq_xfer(4'h1, 32'd1000);
        seq_xfer(4'h2, 32'd1);
        idle();
        chk("pri_done", 32'(seq_done), 32'd1);

        // second sequencer write never acked
        @(negedge clk); seq_start = 1'b1; #1;
        idle();
        seq_xfer(4'h0, 32'd99);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); wdg_ack = 1'b0; #1;
            chk("tmo_req", 32'(wdg_req), 32'd1);
            if (i == 0) chk("tmo_addr", 32'(wdg_addr), 32'd1);
        end
        idle();
        chk("tmo_req_drop", 32'(wdg_req),  32'd0);
        chk("tmo_err",      32'(seq_err),  32'd1);
        chk("tmo_done",     32'(seq_done), 32'd0);
        chk("tmo_busy",     32'(seq_busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("tmo_no_third", 32'(wdg_req), 32'd0);
        end
        chk("tmo_err_sticky", 32'(seq_err), 32'd1);

        // CPU read never acked
        @(negedge clk); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h3; wdg_rdata = 32'h1234; #1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); cpu_req = 1'b0; #1;
            chk("ctmo_req", 32'(wdg_req), 32'd1);
            if (i < 15) begin
                chk("ctmo_ack_early", 32'(cpu_ack), 32'd0);
            end else begin
                chk("ctmo_ack",   32'(cpu_ack), 32'd1);
                chk("ctmo_err",   32'(cpu_err), 32'd1);
                chk("ctmo_rdata", cpu_rdata,    32'h0);
            end
        end
        idle();
        chk("ctmo_req_drop", 32'(wdg_req), 32'd0);
        chk("ctmo_ack_end",  32'(cpu_ack), 32'd0);
        wdg_rdata = 32'h0;

        // wdg_res_n low mid-sequence, then released
        @(negedge clk); seq_start = 1'b1; #1;
        idle();
        seq_xfer(4'h0, 32'd99);
        chk("ab_err_cleared", 32'(seq_err), 32'd0);
        @(negedge clk); wdg_ack = 1'b0; wdg_res_n = 1'b0; #1;
        @(negedge clk); #1;
        chk("ab_busy", 32'(seq_busy), 32'd0);
        chk("ab_req",  32'(wdg_req),  32'd0);
        chk("ab_err",  32'(seq_err),  32'd0);
        @(negedge clk); wdg_res_n = 1'b1; #1;
        chk("ab_busy_rise", 32'(seq_busy), 32'd0);
        idle();
        seq_xfer(4'h0, 32'd99);
        chk("ab_restart_err", 32'(seq_err), 32'd0);
        seq_xfer(4'h1, 32'd1000);
        seq_xfer(4'h2, 32'd1);
        idle();
        chk("ab_done", 32'(seq_done), 32'd1);
        chk("ab_err_end", 32'(seq_err), 32'd0);

        // CPU write to the control register after seq_done
        @(negedge clk); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'h2; cpu_wdata = 32'h7; #1;
        chk("lk_req_c0", 32'(wdg_req), 32'd0);
`ifdef WDG_CFG_LOCK_EN
        idle();
        chk("lk_ack",   32'(cpu_ack), 32'd1);
        chk("lk_err",   32'(cpu_err), 32'd1);
        chk("lk_req",   32'(wdg_req), 32'd0);
        chk("lk_rdata", cpu_rdata,    32'h0);
        idle();
        chk("lk_ack_end", 32'(cpu_ack), 32'd0);
        chk("lk_req_end", 32'(wdg_req), 32'd0);
`else
        idle();
        chk("ctl_req",   32'(wdg_req),  32'd1);
        chk("ctl_addr",  32'(wdg_addr), 32'd2);
        chk("ctl_wdata", wdg_wdata,     32'h7);
        @(negedge clk); wdg_ack = 1'b1; #1;
        chk("ctl_ack", 32'(cpu_ack), 32'd1);
        chk("ctl_err", 32'(cpu_err), 32'd0);
        idle();
        chk("ctl_ack_end", 32'(cpu_ack), 32'd0);
`endif

        // sys_res clears status
        @(negedge clk); sys_res = 1'b1; #1;
        @(negedge clk); sys_res = 1'b0; #1;
        chk("rst2_done", 32'(seq_done), 32'd0);
        chk("rst2_req",  32'(wdg_req),  32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/wdg_cfg_arb.md
WDG_CFG_ARB -- requirements
Module: wdg_cfg_arb

Interface
REQ-001 SHALL have parameter PRE_ADDR, default 4'h0, the watchdog prescaler register address.
REQ-002 SHALL have parameter PRE_VAL, default 32'd99, the prescaler value written by the sequencer.
REQ-003 SHALL have parameter TO_ADDR, default 4'h1, the timeout register address.
REQ-004 SHALL have parameter TO_VAL, default 32'd1000, the timeout value written.
REQ-005 SHALL have parameter CTRL_ADDR, default 4'h2, the control register address.
REQ-006 SHALL have parameter CTRL_VAL, default 32'h1, the control value written, with bit0 as enable.
REQ-007 SHALL have parameter ACK_TIMEOUT, default 16, the maximum cycles wdg_req stays high without wdg_ack; legal range 2..255.
REQ-008 SHALL have ports:
- clk  in  1  system clock; one clock, all logic on its rising edge.
- sys_res  in  1  reset, synchronous, active-high.
- wdg_res_n  in  1  watchdog reset from the reset controller; active-low.
- seq_start  in  1  single-cycle software-independent sequence trigger.
- cpu_req / cpu_we  in  1 / 1  CPU request and write-enable.
- cpu_addr / cpu_wdata  in  4 / 32  CPU request address and write data.
- cpu_ack / cpu_err  out  1 / 1  completion pulse and error pulse.
- cpu_rdata  out  32  read data, valid with cpu_ack.
- wdg_req / wdg_we  out  1 / 1  watchdog bus request and write-enable.
- wdg_addr / wdg_wdata  out  4 / 32  watchdog bus address and write data.
- wdg_ack  in  1  watchdog single-cycle acknowledge.
- wdg_rdata  in  32  watchdog read data, valid with wdg_ack.
- seq_busy / seq_done / seq_err  out  1 each  sequencer status.

Function
REQ-009 SHALL implement states S_IDLE, S_CPU, S_SEQ and S_LOCKERR.
REQ-010 SHALL form a trigger from seq_start=1 or a rising edge of wdg_res_n, using a registered copy of wdg_res_n whose reset value is 1.
REQ-011 SHALL latch a trigger as pending in any state except S_SEQ, and SHALL ignore a trigger while in S_SEQ.
REQ-012 In S_IDLE, a pending trigger with wdg_res_n=1 SHALL have priority: go to S_SEQ, index 0, clear pending, seq_done and seq_err.
REQ-013 Otherwise, in S_IDLE, cpu_req=1 SHALL latch cpu_we/addr/wdata and go to S_CPU, so wdg_req rises one cycle after cpu_req.
REQ-014 In S_CPU, wdg_req/we/addr/wdata SHALL be driven from the latched values.
REQ-015 In S_CPU, cpu_ack SHALL equal wdg_ack combinationally and cpu_rdata SHALL equal wdg_rdata; on wdg_ack the block SHALL return to S_IDLE.
REQ-016 In S_SEQ, the sequencer SHALL write (PRE_ADDR,PRE_VAL), then (TO_ADDR,TO_VAL), then (CTRL_ADDR,CTRL_VAL) with wdg_we=1, one transfer per ack, with no idle cycle between transfers.
REQ-017 After the third ack, the block SHALL return to S_IDLE and set seq_done=1 (level) in the following cycle.
REQ-018 seq_busy SHALL equal 1 exactly while in S_SEQ; the CPU SHALL be stalled during that time, with cpu_ack=0.
REQ-019 The timeout counter SHALL clear when wdg_req is 0 or on ack, and SHALL increment per cycle while wdg_req=1.
REQ-020 When the timeout counter reaches ACK_TIMEOUT-1 with no ack, wdg_req SHALL drop and the block SHALL go to S_IDLE.
REQ-021 On timeout in S_CPU, cpu_ack and cpu_err SHALL pulse together with cpu_rdata=0.
REQ-022 On timeout in S_SEQ, the sequence SHALL abort, seq_err=1 (sticky), and seq_done SHALL remain 0.
REQ-023 If wdg_res_n=0 in any cycle in S_SEQ, the sequence SHALL abort to S_IDLE without setting seq_err; the next rising edge re-triggers it.
REQ-024 cpu_rdata SHALL be 0 whenever cpu_ack=0.
REQ-025 All other outputs SHALL be 0 outside their active state.

Reset
REQ-026 sys_res=1 SHALL force S_IDLE, set all outputs to 0, clear pending, index and timeout counter, and set the registered wdg_res_n copy to 1.
REQ-027 sys_res SHALL take priority over every other input in the same cycle.

Configuration
REQ-028 With macro WDG_CFG_LOCK_EN defined, a CPU write (cpu_we=1) to CTRL_ADDR while seq_done=1 SHALL not be forwarded.
REQ-029 Such a locked write SHALL enter S_LOCKERR for one cycle, pulse cpu_ack and cpu_err, and keep wdg_req=0.
REQ-030 With WDG_CFG_LOCK_EN defined, CPU reads of any address and CPU writes to other addresses SHALL be unaffected.
REQ-031 Without WDG_CFG_LOCK_EN, S_LOCKERR SHALL be absent and all CPU writes SHALL be forwarded.

Verification
REQ-032 Bench: pulse seq_start, watchdog acks each request 2 cycles after it rises -> writes 0/99, 1/1000, 2/1 in order; seq_done=1; seq_busy high exactly for the transfer cycles.
REQ-033 Bench: cpu_req read addr 1, watchdog acks at cycle 3 with rdata 32'hABCD -> wdg_req rises 1 cycle after cpu_req; cpu_ack with rdata 32'hABCD in the same cycle as wdg_ack.
REQ-034 Bench: wdg_res_n rises while a CPU transfer is in S_CPU -> CPU transfer completes first; S_SEQ starts the cycle after the return to S_IDLE.
REQ-035 Bench: watchdog never acks the second sequencer write -> wdg_req drops after 16 cycles; seq_err=1; seq_done=0; no third write issued.
REQ-036 Bench: wdg_res_n=0 mid-sequence, then released -> sequence aborts; on the rise it restarts from PRE_ADDR with seq_err=0.
REQ-037 Bench, with WDG_CFG_LOCK_EN defined: after seq_done=1, CPU write to addr 2 -> cpu_ack and cpu_err pulse; wdg_req remains 0.
